// File: rtl/ir_packet_pkg.sv
// rtl/ir_packet_pkg.sv - shared types and per-car timing tables for the IR packet transmitter
//
// Contents:
//   car_sel_e    : car select encoding (BLUE, YELLOW, GREEN, RED)
//   state_e      : packet sequencer states
//   *_TBL        : per-car constants, indexed by car_sel_e.
//                  HALF_TBL is in CLK cycles; all others are in carrier periods.
//   is_burst()   : true for states that put the carrier on the LED
package ir_packet_pkg;

  typedef enum logic [1:0] {
    BLUE   = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    RED    = 2'd3
  } car_sel_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_GAP    = 3'd2,
    S_CARSEL = 3'd3,
    S_BIT    = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  //                                          blue  yellow green red
  localparam int unsigned HALF_TBL     [4] = '{1389, 1250, 1333, 1250};
  localparam int unsigned START_TBL    [4] = '{ 191,   88,   88,  192};
  localparam int unsigned GAP_TBL      [4] = '{  25,   40,   40,   24};
  localparam int unsigned CARSEL_TBL   [4] = '{  47,   22,   44,   24};
  localparam int unsigned ASSERT_TBL   [4] = '{  47,   44,   44,   48};
  localparam int unsigned DEASSERT_TBL [4] = '{  22,   22,   22,   24};

  function automatic logic is_burst(input state_e s);
    return (s == S_START) || (s == S_CARSEL) || (s == S_BIT);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - carrier half-period counter with period tick
//
// Ports:
//   CLK, RESET   : system clock, synchronous active-high reset
//   clear        : restart the carrier at the beginning of a high phase
//   half         : carrier half-period in CLK cycles (must be >= 1)
//   carrier_nxt  : carrier value for the next cycle (high during the first
//                  half of each period), so the caller can register it
//   period_tick  : high on the last cycle of each carrier period
module ir_carrier_gen #(
  parameter int HALF_W = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic [HALF_W-1:0] half,
  output logic              carrier_nxt,
  output logic              period_tick
);

  logic [HALF_W-1:0] half_cnt;
  logic              phase;     // 0 = high half, 1 = low half
  logic              half_end;

  assign half_end    = (half_cnt == half - 1'b1);
  assign period_tick = phase & half_end;
  // A clear always lands on phase 0, i.e. the carrier's high half.
  assign carrier_nxt = clear ? 1'b1 : ~(half_end ? ~phase : phase);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_packet_tx.sv
// rtl/ir_packet_tx.sv - multi-car IR packet transmitter
//
// Ports:
//   CLK, RESET   : system clock, synchronous active-high reset
//   SEND_PACKET  : request, accepted in IDLE or in the FINISH (DONE) cycle
//   CAR_SEL      : car select (0 blue, 1 yellow, 2 green, 3 red), latched on accept
//   COMMAND      : command bits sent LSB first, latched on accept
//   BUSY         : high while a packet is on the air (through the last gap)
//   DONE         : one-cycle pulse when a packet completes
//   IR_LED       : registered modulated carrier
//
// HALF_SHIFT divides the carrier half-period by 2**HALF_SHIFT for fast
// simulation; it must be 0 for hardware.
module ir_packet_tx #(
  parameter int CMD_W      = 4,
  parameter int HALF_W     = 12,
  parameter int PULSE_W    = 8,
  parameter int HALF_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SEND_PACKET,
  input  logic [1:0]       CAR_SEL,
  input  logic [CMD_W-1:0] COMMAND,
  output logic             BUSY,
  output logic             DONE,
  output logic             IR_LED
);
  import ir_packet_pkg::*;

  localparam int IDX_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_W - 1);

  state_e              state, state_d;
  state_e              gap_next, gap_next_d;   // where the current GAP leads
  logic [IDX_W-1:0]    bit_idx, bit_idx_d;
  logic [PULSE_W-1:0]  seg_cnt, seg_cnt_d;
  car_sel_e            car_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [HALF_W-1:0]   half_q;
  logic                ir_led_q;
  logic                accept;
  logic                carrier_nxt;
  logic                period_tick;
  logic                seg_last;
  int unsigned         seg_len;

  ir_carrier_gen #(.HALF_W(HALF_W)) u_carrier (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear       (accept),
    .half        (half_q),
    .carrier_nxt (carrier_nxt),
    .period_tick (period_tick)
  );

  // Length of the current segment in carrier periods.
  always_comb begin
    seg_len = 1;
    case (state)
      S_START:  seg_len = START_TBL[car_q];
      S_GAP:    seg_len = GAP_TBL[car_q];
      S_CARSEL: seg_len = CARSEL_TBL[car_q];
      S_BIT:    seg_len = cmd_q[bit_idx] ? ASSERT_TBL[car_q] : DEASSERT_TBL[car_q];
      default:  seg_len = 1;
    endcase
  end

  assign seg_last = (seg_cnt == PULSE_W'(seg_len - 1));

  always_comb begin
    state_d    = state;
    gap_next_d = gap_next;
    bit_idx_d  = bit_idx;
    seg_cnt_d  = seg_cnt;
    accept     = 1'b0;
    case (state)
      S_IDLE: accept = SEND_PACKET;
      S_FINISH: begin
        state_d = S_IDLE;
        accept  = SEND_PACKET;
      end
      default: begin
        // Segments only end on carrier-period boundaries.
        if (period_tick) begin
          if (seg_last) begin
            seg_cnt_d = '0;
            case (state)
              S_START: begin
                state_d    = S_GAP;
                gap_next_d = S_CARSEL;
              end
              S_CARSEL: begin
                state_d    = S_GAP;
                gap_next_d = S_BIT;
              end
              S_BIT: begin
                state_d = S_GAP;
                if (bit_idx == LAST_IDX) begin
                  gap_next_d = S_FINISH;
                end else begin
                  gap_next_d = S_BIT;
                  bit_idx_d  = bit_idx + 1'b1;
                end
              end
              default: state_d = gap_next;
            endcase
          end else begin
            seg_cnt_d = seg_cnt + 1'b1;
          end
        end
      end
    endcase
    if (accept) begin
      state_d   = S_START;
      seg_cnt_d = '0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      gap_next <= S_IDLE;
      bit_idx  <= '0;
      seg_cnt  <= '0;
      car_q    <= BLUE;
      cmd_q    <= '0;
      half_q   <= HALF_W'(HALF_TBL[BLUE] >> HALF_SHIFT);
      ir_led_q <= 1'b0;
    end else begin
      state    <= state_d;
      gap_next <= gap_next_d;
      bit_idx  <= bit_idx_d;
      seg_cnt  <= seg_cnt_d;
      if (accept) begin
        car_q  <= car_sel_e'(CAR_SEL);
        cmd_q  <= COMMAND;
        half_q <= HALF_W'(HALF_TBL[CAR_SEL] >> HALF_SHIFT);
      end
      ir_led_q <= is_burst(state_d) & carrier_nxt;
    end
  end

  assign BUSY   = (state != S_IDLE) && (state != S_FINISH);
  assign DONE   = (state == S_FINISH);
  assign IR_LED = ir_led_q;

endmodule

// File: tb/tb_ir_packet_tx.sv
// tb/tb_ir_packet_tx.sv - directed self-checking bench for ir_packet_tx
module tb_ir_packet_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       f_send, f_busy, f_done, f_led;
  logic [1:0] f_car;
  logic [3:0] f_cmd;
  logic       s_send, s_busy, s_done, s_led;
  logic [1:0] s_car;
  logic [3:0] s_cmd;

  always #5 CLK = ~CLK;

  // Scaled instance: half-periods divided by 128 (blue 10, yellow 9, green 10, red 9).
  ir_packet_tx #(.CMD_W(4), .HALF_W(12), .PULSE_W(8), .HALF_SHIFT(7)) u_fast (
    .CLK(CLK), .RESET(RESET), .SEND_PACKET(f_send), .CAR_SEL(f_car),
    .COMMAND(f_cmd), .BUSY(f_busy), .DONE(f_done), .IR_LED(f_led)
  );

  // Full-scale instance for real carrier half-periods.
  ir_packet_tx u_full (
    .CLK(CLK), .RESET(RESET), .SEND_PACKET(s_send), .CAR_SEL(s_car),
    .COMMAND(s_cmd), .BUSY(s_busy), .DONE(s_done), .IR_LED(s_led)
  );

  int errors = 0;
  int checks = 0;
  int busy_cyc, nb, dones, idle_hi;
  int pulses [8];
  int exp6 [6];
  int hi, lo, extra_busy, extra_done;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Watch u_fast from the current sample until DONE (or budget). Bursts are
  // split on LED-low runs longer than one carrier period; pulses[] counts
  // carrier periods per burst. inj_at >= 0 injects a different request.
  task automatic watch(input int hp, input int budget, input int inj_at);
    int   low_run;
    logic prev;
    busy_cyc = 0; nb = 0; dones = 0; idle_hi = 0;
    for (int i = 0; i < 8; i++) pulses[i] = 0;
    low_run = 1 << 20;
    prev = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (f_led && !prev) begin
        if (low_run > 2 * hp) nb++;
        if (nb >= 1 && nb <= 8) pulses[nb-1]++;
      end
      low_run = f_led ? 0 : low_run + 1;
      prev = f_led;
      if (f_busy) busy_cyc++;
      else if (f_led) idle_hi++;
      if (inj_at >= 0 && c == inj_at) begin
        f_send = 1'b1; f_car = 2'd0; f_cmd = 4'b1111;
      end
      if (inj_at >= 0 && c == inj_at + 1) f_send = 1'b0;
      if (f_done) begin
        dones++;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic chk_packet(input string tag, input int exp_busy);
    chk({tag, "_done"}, dones, 1);
    chk({tag, "_busy_at_done"}, int'(f_busy), 0);
    chk({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    chk({tag, "_bursts"}, nb, 6);
    chk({tag, "_led_while_idle"}, idle_hi, 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_burst%0d", tag, i), pulses[i], exp6[i]);
  endtask

  task automatic send_fast(input logic [1:0] car, input logic [3:0] cmd);
    f_car = car; f_cmd = cmd; f_send = 1'b1;
    @(negedge CLK);
    f_send = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    f_send = 1'b0; f_car = 2'd0; f_cmd = 4'd0;
    s_send = 1'b0; s_car = 2'd0; s_cmd = 4'd0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(f_busy), 0);
    chk("rst_done", int'(f_done), 0);
    chk("rst_led", int'(f_led), 0);
    chk("rst_full_busy", int'(s_busy), 0);
    chk("rst_full_done", int'(s_done), 0);
    chk("rst_full_led", int'(s_led), 0);
    RESET = 1'b0;
    @(negedge CLK);

    // Yellow full-scale carrier: 1250 high, 1250 low.
    s_car = 2'd1; s_cmd = 4'd0; s_send = 1'b1;
    @(negedge CLK);
    s_send = 1'b0;
    chk("yellow_busy_after_accept", int'(s_busy), 1);
    chk("yellow_led_after_accept", int'(s_led), 1);
    hi = 0;
    while (s_led && hi < 5000) begin hi++; @(negedge CLK); end
    chk("yellow_high_phase", hi, 1250);
    lo = 0;
    while (!s_led && lo < 5000) begin lo++; @(negedge CLK); end
    chk("yellow_low_phase", lo, 1250);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;

    // Green full-scale carrier: 1333 high.
    s_car = 2'd2; s_send = 1'b1;
    @(negedge CLK);
    s_send = 1'b0;
    hi = 0;
    while (s_led && hi < 5000) begin hi++; @(negedge CLK); end
    chk("green_high_phase", hi, 1333);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Blue 0101: 526 periods of 20 cycles.
    send_fast(2'd0, 4'b0101);
    chk("blue_busy_after_accept", int'(f_busy), 1);
    chk("blue_led_after_accept", int'(f_led), 1);
    watch(10, 12000, -1);
    exp6 = '{191, 47, 47, 22, 47, 22};
    chk_packet("blue", 526 * 20);
    @(negedge CLK);
    chk("blue_done_one_cycle", int'(f_done), 0);

    // Red 0000: 456 periods of 18 cycles, every bit 24 periods.
    send_fast(2'd3, 4'b0000);
    watch(9, 10000, -1);
    exp6 = '{192, 24, 24, 24, 24, 24};
    chk_packet("red", 456 * 18);
    @(negedge CLK);

    // Request mid-packet with other car/command is ignored.
    send_fast(2'd3, 4'b0000);
    watch(9, 10000, 2000);
    chk_packet("mid_req", 456 * 18);
    extra_busy = 0; extra_done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (f_busy) extra_busy++;
      if (f_done) extra_done++;
    end
    chk("mid_req_no_resend_busy", extra_busy, 0);
    chk("mid_req_no_resend_done", extra_done, 0);

    // SEND_PACKET held high: back-to-back with one BUSY=0 cycle.
    f_car = 2'd3; f_cmd = 4'b0000; f_send = 1'b1;
    @(negedge CLK);
    watch(9, 10000, -1);
    chk_packet("b2b_first", 456 * 18);
    @(negedge CLK);
    chk("b2b_restart_busy", int'(f_busy), 1);
    chk("b2b_restart_led", int'(f_led), 1);
    watch(9, 10000, -1);
    f_send = 1'b0;
    chk_packet("b2b_second", 456 * 18);
    @(negedge CLK);
    chk("b2b_stop_busy", int'(f_busy), 0);

    // Reset during the CARSEL burst (cycle 3909: second CARSEL period, high phase).
    send_fast(2'd3, 4'b0000);
    repeat (3888 + 20) @(negedge CLK);
    chk("carsel_led_before_reset", int'(f_led), 1);
    chk("carsel_busy_before_reset", int'(f_busy), 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("reset_mid_busy", int'(f_busy), 0);
    chk("reset_mid_led", int'(f_led), 0);
    chk("reset_mid_done", int'(f_done), 0);
    RESET = 1'b0;
    extra_busy = 0; extra_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (f_busy) extra_busy++;
      if (f_done) extra_done++;
    end
    chk("reset_abandon_busy", extra_busy, 0);
    chk("reset_abandon_done", extra_done, 0);

    // Red 1010 after reset: 504 periods of 18 cycles.
    send_fast(2'd3, 4'b1010);
    watch(9, 10000, -1);
    exp6 = '{192, 24, 24, 48, 24, 48};
    chk_packet("after_reset", 504 * 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
